// File: rtl/seq_pkg.sv
// ============================================================================
// Module  : seq_pkg
// Brief   : Microcommand bit positions and sequencer state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

   localparam int UC_W                   = 28;
   localparam int UC_END                 = 0;
   localparam int UC_IR_LOAD             = 1;
   localparam int UC_IMM_EXTEND_NEGATIVE = 5;
   localparam int UC_IMM_SHIFT           = 6;

   localparam int RESET_VEC_DEFAULT      = 0;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXEC  = 3'd1,
      ST_EXC   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ucode_sequencer_if.sv
// ============================================================================
// Module  : ucode_sequencer_if
// Brief   : Microcode/bus/interrupt handshake bundle feeding the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ucode_sequencer_if #(
   parameter int VEC_W = 6
);
   import seq_pkg::*;

   logic [UC_W-1:0]  ucommand;
   logic             mem_ready;
   logic [15:0]      mem_rdata;
   logic             irq_req;
   logic [VEC_W-1:0] irq_vec;
   logic             irq_ack;

   modport master (
      output ucommand, mem_ready, mem_rdata, irq_req, irq_vec,
      input  irq_ack
   );

   modport slave (
      input  ucommand, mem_ready, mem_rdata, irq_req, irq_vec,
      output irq_ack
   );

endinterface

`default_nettype wire

// File: rtl/seq_boundary_arb.sv
// ============================================================================
// Module  : seq_boundary_arb
// Brief   : Next state / interrupt-enable selection at a microprogram end.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_boundary_arb
   import seq_pkg::*;
(
   input  state_t i_state,
   input  logic   i_dec_halt,
   input  logic   i_dec_wait,
   input  logic   i_dec_ei,
   input  logic   i_dec_di,
   input  logic   i_dec_rti,
   input  logic   i_irq_req,
   input  logic   i_ie,
   output state_t o_state,
   output logic   o_ie,
   output logic   o_take_irq
);

   always_comb begin
      o_state    = i_state;
      o_ie       = i_ie;
      o_take_irq = 1'b0;
      case (i_state)
         ST_FETCH: o_state = ST_EXEC;
         ST_EXC:   o_state = ST_FETCH;
         ST_EXEC: begin
            if (i_dec_ei || i_dec_rti) begin
               o_ie = 1'b1;
            end else if (i_dec_di) begin
               o_ie = 1'b0;
            end
            // i_ie is the pre-update flag, giving EI its one-instruction shadow
            if (i_dec_halt) begin
               o_state = ST_HALT;
            end else if (i_dec_wait) begin
               o_state = ST_WAIT;
            end else if (i_irq_req && i_ie) begin
               o_state    = ST_EXC;
               o_ie       = 1'b0;
               o_take_irq = 1'b1;
            end else begin
               o_state = ST_FETCH;
            end
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ucode_sequencer.sv
// ============================================================================
// Module  : ucode_sequencer
// Brief   : Phase counter, instruction register and fetch/exec/exception FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ucode_sequencer
   import seq_pkg::*;
#(
   parameter int PHASE_W   = 3,
   parameter int VEC_W     = 6,
   parameter int RESET_VEC = RESET_VEC_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   ucode_sequencer_if.slave    bus,
   input  logic                dec_halt,
   input  logic                dec_wait,
   input  logic                dec_ei,
   input  logic                dec_di,
   input  logic                dec_rti,
   output logic [15:0]         ir,
   output logic [PHASE_W-1:0]  phase,
   output logic                fetch,
   output logic                exc_triggered,
   output logic [VEC_W-1:0]    exc_vec,
   output logic                ie,
   output logic                halted,
   output logic                waiting,
   output logic                uc_overrun
);

   localparam logic [PHASE_W-1:0] C_PHASE_MAX = '1;

   state_t             r_state, w_state_nxt, w_arb_state;
   logic [PHASE_W-1:0] r_phase, w_phase_nxt;
   logic [15:0]        r_ir, w_ir_nxt;
   logic               r_ie, w_ie_nxt, w_arb_ie, w_arb_irq;
   logic [VEC_W-1:0]   r_exc_vec, w_exc_vec_nxt;
   logic               r_irq_ack, w_irq_ack_nxt;
   logic               r_overrun, w_overrun_nxt;
   logic               w_unused_uc;

   assign w_unused_uc = ^bus.ucommand[UC_W-1:2];

   seq_boundary_arb u_arb (
      .i_state    (r_state),
      .i_dec_halt (dec_halt),
      .i_dec_wait (dec_wait),
      .i_dec_ei   (dec_ei),
      .i_dec_di   (dec_di),
      .i_dec_rti  (dec_rti),
      .i_irq_req  (bus.irq_req),
      .i_ie       (r_ie),
      .o_state    (w_arb_state),
      .o_ie       (w_arb_ie),
      .o_take_irq (w_arb_irq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_EXC;
         r_phase   <= '0;
         r_ir      <= '0;
         r_ie      <= 1'b0;
         r_exc_vec <= VEC_W'(RESET_VEC);
         r_irq_ack <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_ir      <= w_ir_nxt;
         r_ie      <= w_ie_nxt;
         r_exc_vec <= w_exc_vec_nxt;
         r_irq_ack <= w_irq_ack_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_phase_nxt   = r_phase;
      w_ir_nxt      = r_ir;
      w_ie_nxt      = r_ie;
      w_exc_vec_nxt = r_exc_vec;
      w_irq_ack_nxt = 1'b0;
      w_overrun_nxt = r_overrun;
      case (r_state)
         ST_FETCH, ST_EXEC, ST_EXC: begin
            if (bus.mem_ready) begin
               if (bus.ucommand[UC_IR_LOAD]) begin
                  w_ir_nxt = bus.mem_rdata;
               end
               if (bus.ucommand[UC_END]) begin
                  w_phase_nxt = '0;
                  w_state_nxt = w_arb_state;
                  w_ie_nxt    = w_arb_ie;
                  if (w_arb_irq) begin
                     w_irq_ack_nxt = 1'b1;
                     w_exc_vec_nxt = bus.irq_vec;
                  end
               end else if (r_phase == C_PHASE_MAX) begin
                  // Runaway microprogram: stop the core rather than wrap the phase
                  w_overrun_nxt = 1'b1;
                  w_state_nxt   = ST_HALT;
               end else begin
                  w_phase_nxt = r_phase + PHASE_W'(1);
               end
            end
         end
         ST_WAIT: begin
            if (bus.irq_req && r_ie) begin
               w_state_nxt   = ST_EXC;
               w_irq_ack_nxt = 1'b1;
               w_exc_vec_nxt = bus.irq_vec;
               w_ie_nxt      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign ir            = r_ir;
   assign phase         = r_phase;
   assign fetch         = (r_state == ST_FETCH);
   assign exc_triggered = (r_state == ST_EXC);
   assign exc_vec       = r_exc_vec;
   assign ie            = r_ie;
   assign bus.irq_ack   = r_irq_ack;
   assign halted        = (r_state == ST_HALT);
   assign waiting       = (r_state == ST_WAIT);
   assign uc_overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
// ============================================================================
// Module  : tb_ucode_sequencer
// Brief   : Directed self-checking bench for the microcode sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ucode_sequencer;
   import seq_pkg::*;

   localparam logic [UC_W-1:0] UC_END_WORD = UC_W'(1) << UC_END;
   localparam logic [UC_W-1:0] UC_LD_WORD  = UC_W'(1) << UC_IR_LOAD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_halt, dec_wait, dec_ei, dec_di, dec_rti;
   logic [15:0] ir;
   logic [2:0]  phase;
   logic        fetch, exc_triggered, ie, halted, waiting, uc_overrun;
   logic [5:0]  exc_vec;
   int          n_tests = 0;
   int          n_fail  = 0;

   ucode_sequencer_if #(.VEC_W(6)) bus ();

   ucode_sequencer #(.PHASE_W(3), .VEC_W(6), .RESET_VEC(0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus.slave),
      .dec_halt      (dec_halt),
      .dec_wait      (dec_wait),
      .dec_ei        (dec_ei),
      .dec_di        (dec_di),
      .dec_rti       (dec_rti),
      .ir            (ir),
      .phase         (phase),
      .fetch         (fetch),
      .exc_triggered (exc_triggered),
      .exc_vec       (exc_vec),
      .ie            (ie),
      .halted        (halted),
      .waiting       (waiting),
      .uc_overrun    (uc_overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_end();
      bus.ucommand = UC_END_WORD;
      step();
      bus.ucommand = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      {dec_halt, dec_wait, dec_ei, dec_di, dec_rti} = '0;
      bus.ucommand = '0; bus.mem_ready = 1'b1; bus.mem_rdata = '0;
      bus.irq_req = 1'b0; bus.irq_vec = '0;
      step(); step();
      n_tests++;
      if ({exc_triggered, fetch, halted, waiting, uc_overrun, ie, bus.irq_ack} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 1000000",
                  {exc_triggered, fetch, halted, waiting, uc_overrun, ie, bus.irq_ack});
      end
      n_tests++;
      if ({phase, ir, exc_vec} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset_regs: got phase=%0d ir=%h vec=%h expected 0/0000/00", phase, ir, exc_vec);
      end
   endtask

   task automatic test_reset_entry();
      rst_n = 1'b1;
      step();
      step();
      n_tests++;
      if (phase !== 3'd2 || exc_triggered !== 1'b1) begin
         n_fail++;
         $display("FAIL entry_phase2: got phase=%0d exc=%b expected 2/1", phase, exc_triggered);
      end
      run_end();
      n_tests++;
      if (fetch !== 1'b1 || exc_triggered !== 1'b0 || phase !== 3'd0 || exc_vec !== 6'h00) begin
         n_fail++;
         $display("FAIL entry_to_fetch: got fetch=%b exc=%b phase=%0d vec=%h expected 1/0/0/00",
                  fetch, exc_triggered, phase, exc_vec);
      end
   endtask

   task automatic test_ir_load_stall();
      step();
      bus.ucommand  = UC_LD_WORD;
      bus.mem_rdata = 16'h2A5C;
      bus.mem_ready = 1'b0;
      step(); step(); step();
      n_tests++;
      if (phase !== 3'd1 || ir !== 16'h0000) begin
         n_fail++;
         $display("FAIL stall_hold: got phase=%0d ir=%h expected 1/0000", phase, ir);
      end
      bus.mem_ready = 1'b1;
      step();
      bus.ucommand = '0;
      n_tests++;
      if (phase !== 3'd2 || ir !== 16'h2A5C) begin
         n_fail++;
         $display("FAIL ir_load: got phase=%0d ir=%h expected 2/2a5c", phase, ir);
      end
      run_end();
      n_tests++;
      if (fetch !== 1'b0 || exc_triggered !== 1'b0 || phase !== 3'd0) begin
         n_fail++;
         $display("FAIL to_exec: got fetch=%b exc=%b phase=%0d expected 0/0/0", fetch, exc_triggered, phase);
      end
   endtask

   task automatic test_ei_shadow();
      dec_ei = 1'b1; bus.irq_req = 1'b1; bus.irq_vec = 6'h05;
      run_end();
      dec_ei = 1'b0;
      n_tests++;
      if (fetch !== 1'b1 || ie !== 1'b1 || bus.irq_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL ei_shadow: got fetch=%b ie=%b ack=%b expected 1/1/0", fetch, ie, bus.irq_ack);
      end
      run_end();
      run_end();
      n_tests++;
      if (exc_triggered !== 1'b1 || bus.irq_ack !== 1'b1 || ie !== 1'b0 || exc_vec !== 6'h05) begin
         n_fail++;
         $display("FAIL irq_take: got exc=%b ack=%b ie=%b vec=%h expected 1/1/0/05",
                  exc_triggered, bus.irq_ack, ie, exc_vec);
      end
      step();
      bus.irq_req = 1'b0;
      n_tests++;
      if (bus.irq_ack !== 1'b0 || phase !== 3'd1) begin
         n_fail++;
         $display("FAIL ack_pulse: got ack=%b phase=%0d expected 0/1", bus.irq_ack, phase);
      end
      run_end();
   endtask

   task automatic test_wait();
      run_end();
      dec_ei = 1'b1;
      run_end();
      dec_ei = 1'b0;
      run_end();
      dec_wait = 1'b1;
      run_end();
      dec_wait = 1'b0;
      n_tests++;
      if (waiting !== 1'b1 || phase !== 3'd0 || ie !== 1'b1) begin
         n_fail++;
         $display("FAIL wait_enter: got waiting=%b phase=%0d ie=%b expected 1/0/1", waiting, phase, ie);
      end
      bus.ucommand = UC_END_WORD;
      for (int i = 0; i < 5; i++) begin
         step();
         n_tests++;
         if (waiting !== 1'b1 || exc_triggered !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_hold[%0d]: got waiting=%b exc=%b expected 1/0", i, waiting, exc_triggered);
         end
      end
      bus.ucommand = '0;
      bus.irq_req = 1'b1; bus.irq_vec = 6'h11;
      step();
      bus.irq_req = 1'b0;
      n_tests++;
      if (exc_triggered !== 1'b1 || exc_vec !== 6'h11 || bus.irq_ack !== 1'b1 || waiting !== 1'b0 || ie !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_wake: got exc=%b vec=%h ack=%b waiting=%b ie=%b expected 1/11/1/0/0",
                  exc_triggered, exc_vec, bus.irq_ack, waiting, ie);
      end
   endtask

   task automatic test_halt_priority();
      run_end();
      run_end();
      dec_ei = 1'b1;
      run_end();
      dec_ei = 1'b0;
      run_end();
      dec_halt = 1'b1; bus.irq_req = 1'b1; bus.irq_vec = 6'h03;
      run_end();
      dec_halt = 1'b0;
      n_tests++;
      if (halted !== 1'b1 || bus.irq_ack !== 1'b0 || exc_triggered !== 1'b0 || ie !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_enter: got halted=%b ack=%b exc=%b ie=%b expected 1/0/0/1",
                  halted, bus.irq_ack, exc_triggered, ie);
      end
      bus.ucommand = UC_END_WORD;
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++;
         if (halted !== 1'b1 || bus.irq_ack !== 1'b0 || phase !== 3'd0) begin
            n_fail++;
            $display("FAIL halt_hold[%0d]: got halted=%b ack=%b phase=%0d expected 1/0/0",
                     i, halted, bus.irq_ack, phase);
         end
      end
      bus.ucommand = '0; bus.irq_req = 1'b0;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (halted !== 1'b0 || exc_triggered !== 1'b1 || ie !== 1'b0 || ir !== 16'h0000) begin
         n_fail++;
         $display("FAIL halt_reset: got halted=%b exc=%b ie=%b ir=%h expected 0/1/0/0000",
                  halted, exc_triggered, ie, ir);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_overrun();
      run_end();
      for (int i = 0; i < 7; i++) step();
      n_tests++;
      if (phase !== 3'd7 || halted !== 1'b0 || uc_overrun !== 1'b0 || fetch !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_overrun: got phase=%0d halted=%b ovr=%b fetch=%b expected 7/0/0/1",
                  phase, halted, uc_overrun, fetch);
      end
      step();
      n_tests++;
      if (uc_overrun !== 1'b1 || halted !== 1'b1 || phase !== 3'd7) begin
         n_fail++;
         $display("FAIL overrun: got ovr=%b halted=%b phase=%0d expected 1/1/7", uc_overrun, halted, phase);
      end
      step();
      n_tests++;
      if (uc_overrun !== 1'b1 || halted !== 1'b1 || phase !== 3'd7 || fetch !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_hold: got ovr=%b halted=%b phase=%0d fetch=%b expected 1/1/7/0",
                  uc_overrun, halted, phase, fetch);
      end
   endtask

   initial begin
      test_reset();
      test_reset_entry();
      test_ir_load_stall();
      test_ei_shadow();
      test_wait();
      test_halt_priority();
      test_overrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
